// File: rtl/router_pkt_source_if.sv
// -----------------------------------------------------------------------------
// router_pkt_source_if
//   Bundles the three faces of the router packet source into one interface:
//     host command  : req_valid, req_ready, req_addr, req_len
//     host payload  : pl_valid, pl_ready, pl_data
//     router input  : data_in, pkt_valid, busy, err
//     status        : pkt_done, pkt_err, cmd_rej, pkt_cnt, err_cnt
//   modport master : the packet source itself (drives the router pins)
//   modport slave  : the environment around it (host sequencer + router)
// -----------------------------------------------------------------------------
interface router_pkt_source_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_addr;
    logic [5:0]       req_len;

    logic             pl_valid;
    logic             pl_ready;
    logic [7:0]       pl_data;

    logic [7:0]       data_in;
    logic             pkt_valid;
    logic             busy;
    logic             err;

    logic             pkt_done;
    logic             pkt_err;
    logic             cmd_rej;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        input  req_valid, req_addr, req_len,
        input  pl_valid, pl_data,
        input  busy, err,
        output req_ready, pl_ready,
        output data_in, pkt_valid,
        output pkt_done, pkt_err, cmd_rej, pkt_cnt, err_cnt
    );

    modport slave (
        output req_valid, req_addr, req_len,
        output pl_valid, pl_data,
        output busy, err,
        input  req_ready, pl_ready,
        input  data_in, pkt_valid,
        input  pkt_done, pkt_err, cmd_rej, pkt_cnt, err_cnt
    );
endinterface

// File: rtl/router_pkt_source.sv
// -----------------------------------------------------------------------------
// router_pkt_source
//   Writer side of the router 1x3 input port. A command (destination address,
//   payload length) is accepted, the whole payload is buffered, and then the
//   packet is streamed to the router as header, payload and parity bytes,
//   stalling whenever the router raises busy. After the parity byte is taken,
//   the router's err flag is watched for ERR_WAIT cycles and the verdict is
//   reported with a one-cycle pkt_done pulse.
//
// Ports
//   clock  in  rising-edge clock
//   rst    in  synchronous active-low reset
//   bus    master modport of router_pkt_source_if:
//            req_valid/req_ready/req_addr/req_len  command handshake
//            pl_valid/pl_ready/pl_data             payload byte stream
//            data_in/pkt_valid (out), busy/err (in) router input pins
//            pkt_done/pkt_err/cmd_rej              per-packet status
//            pkt_cnt/err_cnt                       wrapping statistics
// -----------------------------------------------------------------------------
module router_pkt_source #(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                rst,
    router_pkt_source_if.master bus
);

    localparam int         WAIT_W   = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ERR_WAIT - 1);
    localparam logic [6:0] LEN_MAX  = 7'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_ERRCHK
    } state_t;

    // Control state
    state_t             state_q,   state_d;
    logic [5:0]         idx_q,     idx_d;
    logic [WAIT_W-1:0]  wait_q,    wait_d;
    logic [7:0]         parity_q,  parity_d;
    logic               vld_q,     vld_d;
    logic               done_q,    done_d;
    logic               perr_q,    perr_d;
    logic               rej_q,     rej_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // Datapath state (data_in is still reset so the router pins go quiet)
    logic [7:0]         data_q,    data_d;
    logic [1:0]         addr_q,    addr_d;
    logic [5:0]         len_q,     len_d;
    logic [7:0]         buf_q [MAX_LEN];
    logic               buf_we;

    // A command is dropped if it names the unused port 3, carries no payload,
    // or would overflow the payload buffer.
    function automatic logic cmd_illegal(input logic [1:0] addr, input logic [5:0] len);
        return (len == 6'd0) || (addr == 2'd3) || ({1'b0, len} > LEN_MAX);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        return cnt + {{(CNT_W-1){1'b0}}, inc};
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        parity_d  = parity_q;
        vld_d     = vld_q;
        done_d    = 1'b0;
        perr_d    = perr_q;
        rej_d     = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        data_d    = data_q;
        addr_d    = addr_q;
        len_d     = len_q;
        buf_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (cmd_illegal(bus.req_addr, bus.req_len)) begin
                        rej_d = 1'b1;
                    end else begin
                        addr_d   = bus.req_addr;
                        len_d    = bus.req_len;
                        idx_d    = 6'd0;
                        parity_d = 8'h00;
                        perr_d   = 1'b0;
                        state_d  = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (bus.pl_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ bus.pl_data;
                    if (idx_q == len_q - 6'd1) begin
                        // Header goes out on the very next cycle.
                        idx_d   = 6'd0;
                        data_d  = {len_q, addr_q};
                        vld_d   = 1'b1;
                        state_d = S_HEADER;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end

            S_HEADER: begin
                if (!bus.busy) begin
                    // Payload was folded in during LOAD, so after this the
                    // accumulator already holds the final parity byte.
                    parity_d = parity_q ^ data_q;
                    data_d   = buf_q[0];
                    state_d  = S_PAYLOAD;
                end
            end

            S_PAYLOAD: begin
                if (!bus.busy) begin
                    if (idx_q == len_q - 6'd1) begin
                        data_d  = parity_q;
                        vld_d   = 1'b0;
                        state_d = S_PARITY;
                    end else begin
                        idx_d  = idx_q + 6'd1;
                        data_d = buf_q[idx_q + 6'd1];
                    end
                end
            end

            S_PARITY: begin
                if (!bus.busy) begin
                    data_d  = 8'h00;
                    wait_d  = '0;
                    state_d = S_ERRCHK;
                end
            end

            S_ERRCHK: begin
                perr_d = perr_q | bus.err;
                if (wait_q == WAIT_LAST) begin
                    done_d    = 1'b1;
                    pkt_cnt_d = cnt_inc(pkt_cnt_q, 1'b1);
                    err_cnt_d = cnt_inc(err_cnt_q, perr_d);
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 6'd0;
            wait_q    <= '0;
            parity_q  <= 8'h00;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            rej_q     <= 1'b0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            parity_q  <= parity_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            rej_q     <= rej_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
            data_q    <= data_d;
        end
    end

    // Command fields and payload store are only meaningful after a fresh
    // accept, so they carry no reset.
    always_ff @(posedge clock) begin
        addr_q <= addr_d;
        len_q  <= len_d;
        if (buf_we) begin
            buf_q[idx_q] <= bus.pl_data;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.pl_ready  = (state_q == S_LOAD);
    assign bus.data_in   = data_q;
    assign bus.pkt_valid = vld_q;
    assign bus.pkt_done  = done_q;
    assign bus.pkt_err   = perr_q;
    assign bus.cmd_rej   = rej_q;
    assign bus.pkt_cnt   = pkt_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_router_pkt_source.sv
module tb_router_pkt_source;

    localparam int ERR_WAIT = 3;
    localparam int CNT_W    = 16;

    typedef logic [7:0] bq_t[$];
    typedef logic [8:0] iq_t[$];   // {pkt_valid, byte}

    logic clk;
    logic rst;

    router_pkt_source_if #(.CNT_W(CNT_W)) bus ();

    router_pkt_source #(
        .MAX_LEN (63),
        .ERR_WAIT(ERR_WAIT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock(clk),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Transaction-level model: a packet is a list of bytes to hand over;
    // one list entry leaves per non-busy edge, then a fixed err window.
    // ---------------------------------------------------------------------
    iq_t        tx_q;
    bq_t        m_pl;
    iq_t        cons_log;
    logic       m_loading = 1'b0;
    logic [5:0] m_len     = '0;
    logic [7:0] m_hdr     = '0;
    int         m_errwin  = 0;
    logic       m_perr    = 1'b0;
    logic       m_done    = 1'b0;
    logic       m_rej     = 1'b0;
    logic [CNT_W-1:0] m_cnt  = '0;
    logic [CNT_W-1:0] m_ecnt = '0;
    logic       was_idle;
    int         cnt22      = 0;
    int         rej_seen   = 0;
    int         plr_seen   = 0;
    int         done_seen  = 0;

    always @(posedge clk) begin
        was_idle = !m_loading && (tx_q.size() == 0) && (m_errwin == 0);
        m_done   = 1'b0;
        m_rej    = 1'b0;
        if (!rst) begin
            tx_q.delete();
            m_pl.delete();
            m_loading = 1'b0;
            m_errwin  = 0;
            m_perr    = 1'b0;
            m_cnt     = '0;
            m_ecnt    = '0;
        end else if (was_idle) begin
            if (bus.req_valid) begin
                if (bus.req_len == 6'd0 || bus.req_addr == 2'd3) begin
                    m_rej = 1'b1;
                end else begin
                    m_loading = 1'b1;
                    m_len     = bus.req_len;
                    m_hdr     = {bus.req_len, bus.req_addr};
                    m_perr    = 1'b0;
                    m_pl.delete();
                end
            end
        end else if (m_loading) begin
            if (bus.pl_valid) begin
                m_pl.push_back(bus.pl_data);
                if (m_pl.size() == int'(m_len)) begin
                    logic [7:0] p;
                    p = m_hdr;
                    m_loading = 1'b0;
                    tx_q.push_back({1'b1, m_hdr});
                    foreach (m_pl[i]) begin
                        tx_q.push_back({1'b1, m_pl[i]});
                        p = p ^ m_pl[i];
                    end
                    tx_q.push_back({1'b0, p});
                end
            end
        end else if (tx_q.size() != 0) begin
            if (!bus.busy) begin
                cons_log.push_back({bus.pkt_valid, bus.data_in});
                void'(tx_q.pop_front());
                if (tx_q.size() == 0) m_errwin = ERR_WAIT;
            end
        end else begin
            m_perr   = m_perr | bus.err;
            m_errwin = m_errwin - 1;
            if (m_errwin == 0) begin
                m_done = 1'b1;
                m_cnt  = m_cnt + 1'b1;
                if (m_perr) m_ecnt = m_ecnt + 1'b1;
            end
        end

        #1;
        begin
            logic       e_idle;
            logic [8:0] e_out;
            e_idle = !m_loading && (tx_q.size() == 0) && (m_errwin == 0);
            e_out  = (tx_q.size() != 0) ? tx_q[0] : 9'h000;
            chk("data_in",   32'(bus.data_in),   32'(e_out[7:0]));
            chk("pkt_valid", 32'(bus.pkt_valid), 32'(e_out[8]));
            chk("pkt_done",  32'(bus.pkt_done),  32'(m_done));
            chk("pkt_err",   32'(bus.pkt_err),   32'(m_perr));
            chk("cmd_rej",   32'(bus.cmd_rej),   32'(m_rej));
            chk("pkt_cnt",   32'(bus.pkt_cnt),   32'(m_cnt));
            chk("err_cnt",   32'(bus.err_cnt),   32'(m_ecnt));
            chk("req_ready", 32'(bus.req_ready), 32'(e_idle));
            chk("pl_ready",  32'(bus.pl_ready),  32'(m_loading));
        end
        if (bus.pkt_valid === 1'b1 && bus.data_in === 8'h22) cnt22++;
        if (bus.cmd_rej === 1'b1)  rej_seen++;
        if (bus.pl_ready === 1'b1) plr_seen++;
        if (bus.pkt_done === 1'b1) done_seen++;
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (all drive on the falling edge)
    // ---------------------------------------------------------------------
    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("cmd_timeout", 32'(t), 32'(0));
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic send_payload(input bq_t pl, input int bubble_max);
        for (int i = 0; i < pl.size(); i++) begin
            int nb;
            nb = (bubble_max > 0) ? int'($urandom_range(0, bubble_max)) : 0;
            repeat (nb) begin
                bus.pl_valid = 1'b0;
                @(negedge clk);
            end
            bus.pl_valid = 1'b1;
            bus.pl_data  = pl[i];
            @(negedge clk);
        end
        bus.pl_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.pkt_done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk(name, 32'(t), 32'(0));
    endtask

    task automatic chk_seq(input string name, input int lb, input iq_t exp);
        chk({name, "_len"}, 32'(cons_log.size() - lb), 32'(exp.size()));
        for (int i = 0; i < exp.size() && (lb + i) < cons_log.size(); i++)
            chk(name, 32'(cons_log[lb + i]), 32'(exp[i]));
    endtask

    // ---------------------------------------------------------------------
    // Directed tests
    // ---------------------------------------------------------------------
    initial begin
        bq_t pl;
        iq_t ex;
        int  lb, base, base2, t;

        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.pl_valid  = 1'b0; bus.pl_data  = '0;
        bus.busy      = 1'b0; bus.err      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'(1));
        chk("rst_pl_ready",  32'(bus.pl_ready),  32'(0));
        chk("rst_data_in",   32'(bus.data_in),   32'(0));
        chk("rst_pkt_cnt",   32'(bus.pkt_cnt),   32'(0));
        rst = 1'b1;
        @(negedge clk);

        // T1: addr 1, len 3
        lb = cons_log.size();
        pl = '{8'h11, 8'h22, 8'h33};
        send_cmd(2'd1, 6'd3);
        send_payload(pl, 0);
        wait_done("T1_done_timeout");
        ex = '{9'h10D, 9'h111, 9'h122, 9'h133, 9'h00D};
        chk_seq("T1_seq", lb, ex);
        chk("T1_pkt_err", 32'(bus.pkt_err), 32'(0));
        chk("T1_pkt_cnt", 32'(bus.pkt_cnt), 32'(1));

        // T2: same packet, router stalls two cycles on byte 22
        lb   = cons_log.size();
        base = cnt22;
        send_cmd(2'd1, 6'd3);
        send_payload(pl, 0);
        t = 0;
        while (!(bus.pkt_valid === 1'b1 && bus.data_in === 8'h22) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("T2_find22_timeout", 32'(t), 32'(0));
        bus.busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.busy = 1'b0;
        wait_done("T2_done_timeout");
        chk_seq("T2_seq", lb, ex);
        chk("T2_hold22", 32'(cnt22 - base), 32'(3));
        chk("T2_pkt_cnt", 32'(bus.pkt_cnt), 32'(2));

        // T3: err pulse two cycles after parity is taken
        send_cmd(2'd1, 6'd3);
        send_payload(pl, 0);
        t = 0;
        while (tx_q.size() != 1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("T3_parity_timeout", 32'(t), 32'(0));
        @(negedge clk);
        @(negedge clk);
        bus.err = 1'b1;
        @(negedge clk);
        bus.err = 1'b0;
        wait_done("T3_done_timeout");
        chk("T3_pkt_err", 32'(bus.pkt_err), 32'(1));
        chk("T3_err_cnt", 32'(bus.err_cnt), 32'(1));
        chk("T3_pkt_cnt", 32'(bus.pkt_cnt), 32'(3));

        // T4: illegal commands
        base  = rej_seen;
        base2 = plr_seen;
        send_cmd(2'd1, 6'd0);
        send_cmd(2'd3, 6'd5);
        repeat (3) @(negedge clk);
        chk("T4_rej_pulses", 32'(rej_seen - base), 32'(2));
        chk("T4_pl_ready",   32'(plr_seen - base2), 32'(0));
        chk("T4_pkt_valid",  32'(bus.pkt_valid), 32'(0));

        // T5: reset in the middle of the payload
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_cmd(2'd0, 6'd5);
        send_payload(pl, 0);
        t = 0;
        while (!(bus.pkt_valid === 1'b1 && bus.data_in === 8'h02) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("T5_find02_timeout", 32'(t), 32'(0));
        base = done_seen;
        rst = 1'b0;
        @(negedge clk);
        chk("T5_rst_pkt_valid", 32'(bus.pkt_valid), 32'(0));
        chk("T5_rst_data_in",   32'(bus.data_in),   32'(0));
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("T5_no_done", 32'(done_seen - base), 32'(0));
        lb = cons_log.size();
        pl = '{8'hA5, 8'h5A};
        send_cmd(2'd2, 6'd2);
        send_payload(pl, 0);
        wait_done("T5_done_timeout");
        ex = '{9'h10A, 9'h1A5, 9'h15A, 9'h0F5};
        chk_seq("T5_seq", lb, ex);
        chk("T5_pkt_cnt", 32'(bus.pkt_cnt), 32'(1));

        // T6: full-length packet to port 2 with payload bubbles
        lb = cons_log.size();
        pl.delete();
        ex.delete();
        ex.push_back(9'h1FE);
        for (int i = 1; i <= 63; i++) begin
            pl.push_back(8'(i));
            ex.push_back({1'b1, 8'(i)});
        end
        ex.push_back(9'h0FE);   // FE ^ (1^2^...^63) = FE ^ 00
        send_cmd(2'd2, 6'd63);
        send_payload(pl, 2);
        wait_done("T6_done_timeout");
        chk_seq("T6_seq", lb, ex);
        chk("T6_pkt_cnt", 32'(bus.pkt_cnt), 32'(2));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
